// File: rtl/fc_score_accumulator.sv
// -----------------------------------------------------------------------------
// fc_score_accumulator
//
// Final fully-connected layer of a ten-class classifier. Streams N_IN signed
// activations, multiplies each by one row of ten signed weights held in an
// external synchronous ROM, adds a bias row (scaled by 2^FRAC_W), and
// publishes ten saturated 32-bit class scores.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      one-cycle pulse, begins an inference (honoured in IDLE only)
//   in_valid   activation present on in_data
//   in_ready   block accepts an activation (RUN only)
//   in_data    signed 16-bit activation
//   w_addr     weight-row address (activation index, or N_IN for the bias row)
//   w_data     ten signed 16-bit weights, lane k = bits [16k+15:16k],
//              valid one cycle after w_addr
//   res_0..9   signed 32-bit class scores, updated only on done
//   busy       high in every state except IDLE
//   done       one-cycle pulse coincident with the res_* update
// -----------------------------------------------------------------------------
module fc_score_accumulator #(
    parameter int N_IN   = 64,
    parameter int FRAC_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [15:0]  in_data,
    output logic        [10:0]  w_addr,
    input  logic        [159:0] w_data,
    output logic signed [31:0]  res_0,
    output logic signed [31:0]  res_1,
    output logic signed [31:0]  res_2,
    output logic signed [31:0]  res_3,
    output logic signed [31:0]  res_4,
    output logic signed [31:0]  res_5,
    output logic signed [31:0]  res_6,
    output logic signed [31:0]  res_7,
    output logic signed [31:0]  res_8,
    output logic signed [31:0]  res_9,
    output logic                busy,
    output logic                done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_BIAS  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [10:0] LAST_IDX = 11'(N_IN - 1);
    localparam logic [10:0] BIAS_ROW = 11'(N_IN);

    // Saturating 32-bit signed add. Returns {overflow, clamped_sum}.
    function automatic logic [32:0] sat_add(input logic signed [31:0] a,
                                            input logic signed [31:0] b);
        logic signed [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31])
            sat_add = s[32] ? {1'b1, 32'h8000_0000} : {1'b1, 32'h7FFF_FFFF};
        else
            sat_add = {1'b0, s[31:0]};
    endfunction

    logic        [2:0]  r_state;
    logic        [10:0] r_idx;
    logic signed [15:0] r_act;
    logic               r_pend;
    logic signed [31:0] r_acc [10];
    logic        [9:0]  r_sat;
    logic signed [31:0] r_res [10];

    logic               w_hs;
    logic               w_do_add;
    logic signed [15:0] w_lane   [10];
    logic signed [31:0] w_prod   [10];
    logic signed [31:0] w_bias   [10];
    logic signed [31:0] w_addend [10];
    logic signed [31:0] w_sum    [10];
    logic        [9:0]  w_ovf;
    logic signed [31:0] w_next   [10];

    assign in_ready = (r_state == S_RUN);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign w_addr   = (r_state == S_BIAS) ? BIAS_ROW : r_idx;
    assign w_hs     = (r_state == S_RUN) && in_valid;

    // A product is pending in the cycle after each handshake, when the ROM
    // row for that activation appears on w_data. FLUSH sees the bias row.
    assign w_do_add = r_pend || (r_state == S_FLUSH);

    always_comb begin
        for (int k = 0; k < 10; k++) begin
            w_lane[k]   = w_data[16*k +: 16];
            w_prod[k]   = r_act * w_lane[k];
            w_bias[k]   = 32'(w_lane[k]) <<< FRAC_W;
            w_addend[k] = r_pend ? w_prod[k] : w_bias[k];
            {w_ovf[k], w_sum[k]} = sat_add(r_acc[k], w_addend[k]);
            // A lane that has saturated stays pinned at its clamp value.
            w_next[k]   = (w_do_add && !r_sat[k]) ? w_sum[k] : r_acc[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_act   <= '0;
            r_pend  <= 1'b0;
            r_sat   <= '0;
            for (int k = 0; k < 10; k++) begin
                r_acc[k] <= '0;
                r_res[k] <= '0;
            end
        end else begin
            r_pend <= w_hs;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_idx   <= '0;
                        r_sat   <= '0;
                        for (int k = 0; k < 10; k++) r_acc[k] <= '0;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < 10; k++) begin
                        r_acc[k] <= w_next[k];
                        if (w_do_add && w_ovf[k]) r_sat[k] <= 1'b1;
                    end
                    if (w_hs) begin
                        r_act <= in_data;
                        r_idx <= r_idx + 11'd1;
                        if (r_idx == LAST_IDX) r_state <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    for (int k = 0; k < 10; k++) begin
                        r_acc[k] <= w_next[k];
                        if (w_do_add && w_ovf[k]) r_sat[k] <= 1'b1;
                    end
                    r_state <= S_FLUSH;
                end
                S_FLUSH: begin
                    // Final sum goes straight to the outputs so res_* and
                    // done become visible together in DONE.
                    for (int k = 0; k < 10; k++) begin
                        r_acc[k] <= w_next[k];
                        r_res[k] <= w_next[k];
                        if (w_do_add && w_ovf[k]) r_sat[k] <= 1'b1;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign res_0 = r_res[0];
    assign res_1 = r_res[1];
    assign res_2 = r_res[2];
    assign res_3 = r_res[3];
    assign res_4 = r_res[4];
    assign res_5 = r_res[5];
    assign res_6 = r_res[6];
    assign res_7 = r_res[7];
    assign res_8 = r_res[8];
    assign res_9 = r_res[9];

endmodule
